// File: rtl/dsp_round_pkg.sv
// Shared definitions for the rounding / sigma-delta requantiser family.
package dsp_round_pkg;

  localparam logic [1:0] MODE_TRUNC = 2'b00;
  localparam logic [1:0] MODE_ROUND = 2'b01;
  localparam logic [1:0] MODE_SD    = 2'b10;

  // Residual error of a floor/round by 2^shift spans shift bits plus sign.
  function automatic int err_width(input int shift);
    return shift + 1;
  endfunction

endpackage

// File: rtl/round_quant.sv
// Combinational quantiser: truncate or round-half-up by 2^SHIFT, positive
// clip to the output range, and the residual error for noise shaping.
module round_quant
  import dsp_round_pkg::*;
#(
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_OUT = 16,
  parameter int ERR_WIDTH = err_width(WIDTH_IN - WIDTH_OUT)
) (
  input  logic [WIDTH_IN-1:0]  sum_i,
  input  logic                 sat_i,
  input  logic [1:0]           mode_i,
  output logic [WIDTH_OUT-1:0] q_o,
  output logic                 clip_o,
  output logic [ERR_WIDTH-1:0] err_o
);

  localparam int SHIFT = WIDTH_IN - WIDTH_OUT;
  localparam logic [WIDTH_IN:0]    HALF    = (WIDTH_IN + 1)'(2 ** (SHIFT - 1));
  localparam logic [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT - 1){1'b1}}};

  logic [WIDTH_IN:0]  sum_ext;
  logic [WIDTH_IN:0]  biased;
  logic [WIDTH_IN:0]  resid;
  logic [WIDTH_OUT:0] q_full;
  logic               q_ovf;

  // Dropping the low SHIFT bits of a two's complement value is a floor divide;
  // one guard bit keeps the +half bias from wrapping before the clip test.
  always_comb begin
    sum_ext = {sum_i[WIDTH_IN-1], sum_i};
    biased  = (mode_i == MODE_TRUNC) ? sum_ext : sum_ext + HALF;
    q_full  = biased[WIDTH_IN:SHIFT];
    q_ovf   = (q_full[WIDTH_OUT:WIDTH_OUT-1] == 2'b01);
    clip_o  = q_ovf | sat_i;
    q_o     = q_ovf ? OUT_MAX : q_full[WIDTH_OUT-1:0];
    resid   = sum_ext - {q_o[WIDTH_OUT-1], q_o, {SHIFT{1'b0}}};
    // A clipped beat carries no meaningful residual; restart shaping from 0.
    err_o   = clip_o ? '0 : resid[ERR_WIDTH-1:0];
  end

endmodule

// File: rtl/round_sd_multi.sv
// Multi-channel, time-interleaved requantiser with optional first-order
// sigma-delta error feedback. Two-stage pipeline with AXI-stream handshake.
module round_sd_multi
  import dsp_round_pkg::*;
#(
  parameter int WIDTH_IN  = 18,
  parameter int WIDTH_OUT = 16,
  parameter int NUM_CHAN  = 2,
  localparam int CHW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic                 clear,
  input  logic [WIDTH_IN-1:0]  i_tdata,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  input  logic                 i_tlast,
  output logic [WIDTH_OUT-1:0] o_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 o_tlast,
  output logic [CHW-1:0]       o_chan,
  output logic [15:0]          clip_count
);

  localparam int SHIFT     = WIDTH_IN - WIDTH_OUT;
  localparam int ERR_WIDTH = err_width(SHIFT);
  localparam int NSLOT     = 1 << CHW;
  localparam logic [CHW-1:0]      LAST_CH = CHW'(NUM_CHAN - 1);
  localparam logic [WIDTH_IN-1:0] IN_MAX  = {1'b0, {(WIDTH_IN - 1){1'b1}}};
  localparam logic [WIDTH_IN-1:0] IN_MIN  = {1'b1, {(WIDTH_IN - 1){1'b0}}};

  logic                 en;
  logic                 accept;
  logic                 advance;
  logic                 sd_mode;
  logic                 mode_chg;
  logic                 fwd;
  logic [1:0]           mode_q;
  logic [CHW-1:0]       ch_q;
  logic [CHW-1:0]       ch_d;
  logic [ERR_WIDTH-1:0] err_q [NSLOT];
  logic [ERR_WIDTH-1:0] err_sel;
  logic [WIDTH_IN:0]    sum_w;
  logic [WIDTH_IN-1:0]  sum_d;
  logic                 sat_d;

  logic                 s1_valid_q;
  logic [WIDTH_IN-1:0]  s1_sum_q;
  logic                 s1_sat_q;
  logic                 s1_last_q;
  logic [CHW-1:0]       s1_ch_q;

  logic [WIDTH_OUT-1:0] q_data;
  logic                 q_clip;
  logic [ERR_WIDTH-1:0] q_err;

  assign en       = o_tready | ~o_tvalid;
  assign i_tready = en;
  assign accept   = i_tvalid & en;
  assign advance  = s1_valid_q & en;
  assign sd_mode  = (mode == MODE_SD);
  assign mode_chg = (mode != mode_q);

  // Error addend for the incoming beat; bypass the stored value when the
  // same channel's previous beat is leaving S1 in this very cycle.
  always_comb begin
    fwd     = advance && (s1_ch_q == ch_q);
    err_sel = '0;
    if (sd_mode && !clear && !mode_chg) begin
      err_sel = fwd ? q_err : err_q[ch_q];
    end
  end

  // Input plus error, saturated back to the input width.
  always_comb begin
    sum_w = {i_tdata[WIDTH_IN-1], i_tdata}
          + {{(WIDTH_IN + 1 - ERR_WIDTH){err_sel[ERR_WIDTH-1]}}, err_sel};
    sat_d = (sum_w[WIDTH_IN] != sum_w[WIDTH_IN-1]);
    if (!sat_d)             sum_d = sum_w[WIDTH_IN-1:0];
    else if (sum_w[WIDTH_IN]) sum_d = IN_MIN;
    else                    sum_d = IN_MAX;
  end

  // Next input channel: wrap at NUM_CHAN-1, resync to 0 after a tlast beat.
  always_comb begin
    ch_d = ch_q;
    if (accept) begin
      if (i_tlast || ch_q == LAST_CH) ch_d = '0;
      else                            ch_d = ch_q + 1'b1;
    end
  end

  // Channel counter and last-seen mode (for change detection).
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!reset_n) ch_q <= '0;
    else          ch_q <= ch_d;
  end

  // Stage 1: register the error-compensated sum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_sat_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ch_q    <= '0;
    end else if (en) begin
      s1_valid_q <= i_tvalid;
      if (i_tvalid) begin
        s1_sum_q  <= sum_d;
        s1_sat_q  <= sat_d;
        s1_last_q <= i_tlast;
        s1_ch_q   <= ch_q;
      end
    end
  end

  round_quant #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT),
    .ERR_WIDTH (ERR_WIDTH)
  ) u_quant (
    .sum_i  (s1_sum_q),
    .sat_i  (s1_sat_q),
    .mode_i (mode),
    .q_o    (q_data),
    .clip_o (q_clip),
    .err_o  (q_err)
  );

  // Stage 2: register the quantised output; frozen while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_chan   <= '0;
    end else if (en) begin
      o_tvalid <= s1_valid_q;
      if (s1_valid_q) begin
        o_tdata <= q_data;
        o_tlast <= s1_last_q;
        o_chan  <= s1_ch_q;
      end
    end
  end

  // Per-channel error state; clear and mode changes take priority over writes.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NSLOT; c++) begin
      if (!reset_n || clear || mode_chg) begin
        err_q[c] <= '0;
      end else if (advance && sd_mode && s1_ch_q == CHW'(c)) begin
        err_q[c] <= q_err;
      end
    end
  end

  // Saturating count of clipped beats.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      clip_count <= '0;
    end else if (advance && q_clip && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_round_sd_multi.sv
// Directed self-checking bench for round_sd_multi (18 -> 16 bits).
// u_dut runs two channels; u_dut1 shares the stimulus with one channel.
module tb_round_sd_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic        clear;
  logic [17:0] i_tdata;
  logic        i_tvalid;
  logic        i_tlast;
  logic        o_tready;

  logic        i_tready;
  logic [15:0] o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic [0:0]  o_chan;
  logic [15:0] clip_count;

  logic        a_i_tready;
  logic [15:0] a_o_tdata;
  logic        a_o_tvalid;
  logic        a_o_tlast;
  logic [0:0]  a_o_chan;
  logic [15:0] a_clip_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_sd_multi #(.WIDTH_IN(18), .WIDTH_OUT(16), .NUM_CHAN(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tlast(i_tlast),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .o_chan(o_chan), .clip_count(clip_count)
  );

  round_sd_multi #(.WIDTH_IN(18), .WIDTH_OUT(16), .NUM_CHAN(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(a_i_tready), .i_tlast(i_tlast),
    .o_tdata(a_o_tdata), .o_tvalid(a_o_tvalid), .o_tready(o_tready), .o_tlast(a_o_tlast),
    .o_chan(a_o_chan), .clip_count(a_clip_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] check %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on u_dut with o_tready high; optional clear at the
  // edge where the beat leaves S1.
  task automatic send1(input logic [17:0] d, input logic clr2, input string tag,
                       input logic [15:0] exp);
    i_tdata  = d;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    tick();
    i_tvalid = 1'b0;
    clear    = clr2;
    chk({tag, "_lat1"}, o_tvalid, 1'b0);
    tick();
    clear = 1'b0;
    chk({tag, "_valid"}, o_tvalid, 1'b1);
    chk(tag, o_tdata, exp);
  endtask

  // Constant-1 stream into the single-channel instance, mode 10 assumed;
  // the noise-shaped output must repeat 0,1,0,0.
  task automatic sd_stream(input int n, input string tag, input logic last_final);
    int sent;
    int got;
    sent = 0;
    got  = 0;
    o_tready = 1'b1;
    for (int cyc = 0; cyc < 4 * n + 10 && got < n; cyc++) begin
      i_tvalid = (sent < n);
      i_tdata  = 18'd1;
      i_tlast  = last_final && (sent == n - 1);
      #3;
      if (a_o_tvalid) begin
        chk(tag, a_o_tdata, (got % 4 == 1) ? 1 : 0);
        got++;
      end
      if (i_tvalid && a_i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    int sent;
    int got;
    int n0;
    int exp_ch;
    int exp_d;
    logic stall_prev;
    logic [15:0] prev_data;

    reset_n  = 1'b0;
    mode     = 2'b00;
    clear    = 1'b0;
    i_tdata  = '0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_tready", i_tready, 1'b1);
    chk("rst_tdata", o_tdata, 16'h0000);
    chk("rst_chan", o_chan, 1'b0);
    chk("rst_clip", clip_count, 16'h0000);
    reset_n = 1'b1;
    tick();

    // Truncate and round
    send1(18'd6, 1'b0, "trunc_6", 16'h0001);
    mode = 2'b01;
    tick();
    send1(18'd6, 1'b0, "round_6", 16'h0002);
    send1(18'h3FFFA, 1'b0, "round_m6", 16'hFFFF);
    mode = 2'b11;
    tick();
    send1(18'd6, 1'b0, "mode11_6", 16'h0002);
    mode = 2'b01;
    tick();

    // Clip and saturating counter
    chk("clip_before", clip_count, 16'h0000);
    send1(18'h1FFFF, 1'b0, "clip_max", 16'h7FFF);
    chk("clip_after", clip_count, 16'h0001);
    i_tdata  = 18'h1FFFF;
    i_tvalid = 1'b1;
    repeat (65540) tick();
    i_tvalid = 1'b0;
    repeat (3) tick();
    chk("clip_sat", clip_count, 16'hFFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_clip", clip_count, 16'h0000);
    send1(18'h1FFFF, 1'b1, "clr_coinc", 16'h7FFF);
    chk("clr_coinc_cnt", clip_count, 16'h0000);
    send1(18'h1FFFF, 1'b0, "clip_again", 16'h7FFF);
    chk("clip_again_cnt", clip_count, 16'h0001);

    // Sigma-delta, one channel, back-to-back (forwarding path)
    mode = 2'b10;
    tick();
    sd_stream(8, "sd1", 1'b1);

    // Sigma-delta, two interleaved channels, then tlast resync
    mode = 2'b01;
    tick();
    mode = 2'b10;
    tick();
    sent = 0;
    got  = 0;
    n0   = 0;
    o_tready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 18; cyc++) begin
      i_tvalid = (sent < 18);
      i_tdata  = (sent < 16 && sent % 2 == 1) ? 18'd0 : 18'd1;
      i_tlast  = (sent == 16);
      #3;
      if (o_tvalid) begin
        exp_ch = (got < 16) ? got % 2 : 0;
        if (exp_ch == 0) begin
          exp_d = (n0 % 4 == 1) ? 1 : 0;
          n0++;
        end else begin
          exp_d = 0;
        end
        chk("sd2_data", o_tdata, exp_d);
        chk("sd2_chan", o_chan, exp_ch);
        chk("sd2_last", o_tlast, (got == 16) ? 1 : 0);
        got++;
      end
      if (i_tvalid && i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    chk("sd2_count", got, 18);

    // Random backpressure with continuous input on the single channel
    mode = 2'b01;
    tick();
    mode = 2'b10;
    tick();
    sent = 0;
    got  = 0;
    stall_prev = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      o_tready = 1'($urandom_range(0, 1));
      i_tvalid = (sent < 20);
      i_tdata  = 18'd1;
      i_tlast  = 1'b0;
      #3;
      if (stall_prev) begin
        chk("bp_hold_valid", a_o_tvalid, 1'b1);
        chk("bp_hold_data", a_o_tdata, prev_data);
      end
      if (a_o_tvalid && o_tready) begin
        chk("bp_data", a_o_tdata, (got % 4 == 1) ? 1 : 0);
        got++;
      end
      stall_prev = a_o_tvalid && !o_tready;
      prev_data  = a_o_tdata;
      if (i_tvalid && a_i_tready) sent++;
      tick();
    end
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    chk("bp_count", got, 20);
    tick();
    tick();

    // Reset mid-stream, then mode change and clear
    mode = 2'b01;
    tick();
    send1(18'h1FFFF, 1'b0, "pre_rst_clip", 16'h7FFF);
    chk("pre_rst_cnt", clip_count, 16'h0002);
    mode = 2'b10;
    tick();
    i_tdata  = 18'd1;
    i_tvalid = 1'b1;
    tick();
    tick();
    tick();
    reset_n  = 1'b0;
    i_tvalid = 1'b0;
    tick();
    chk("rst_mid_valid", a_o_tvalid, 1'b0);
    chk("rst_mid_ready", a_i_tready, 1'b1);
    chk("rst_mid_clip", clip_count, 16'h0000);
    tick();
    reset_n = 1'b1;
    mode    = 2'b01;
    tick();
    chk("rst_lost_a", a_o_tvalid, 1'b0);
    chk("rst_lost_b", o_tvalid, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mode  = 2'b10;
    tick();
    chk("post_rst_clip", clip_count, 16'h0000);
    sd_stream(4, "post_rst", 1'b0);
    chk("post_rst_clip2", clip_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
